pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls and taken-branch flushes.
// Ports: clk, rst_n; ID/EX hazard inputs; branch input; pipeline enables and
// flush outputs (Mealy), hz_state (registered), saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BR_FLUSH_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_rt,
    input  logic        mem_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_flush,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_e;

    // Cycles still owed after the current one, loaded when a stall/flush starts.
    localparam logic [1:0] LS_REM =
        (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
    localparam logic [1:0] BR_REM =
        (BR_FLUSH_CYCLES > 0) ? 2'(BR_FLUSH_CYCLES - 1) : 2'd0;

    hz_state_e   state_q, state_d;
    logic [1:0]  remain_q, remain_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        hazard;

    assign hazard = id_valid & ex_mem_read &
                    ((id_uses_rs & (id_rs == ex_rt)) |
                     (id_uses_rt & (id_rt == ex_rt)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        remain_d    = remain_q;

        // Outputs held at defaults while reset is asserted, whatever the inputs.
        if (!rst_n) begin
            state_d  = RUN;
            remain_d = 2'd0;
        end else if (mem_branch_taken) begin
            // Branch outranks any stall; pending stall cycles are dropped.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_d     = (BR_FLUSH_CYCLES > 0) ? FLUSH : RUN;
            remain_d    = BR_REM;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = (LOAD_STALL_CYCLES > 1) ? STALL : RUN;
                        remain_d    = LS_REM;
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (remain_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        remain_d = remain_q - 2'd1;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    if (remain_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        remain_d = remain_q - 2'd1;
                    end
                end
                default: begin
                    state_d  = RUN;
                    remain_d = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (mem_branch_taken && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            remain_q    <= 2'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_state  = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three parameterisations driven in lockstep,
// checked against a remaining-cycles reference model.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [2:0]  ex_rt;
    logic        mem_branch_taken;

    logic [2:0]  pc_write;
    logic [2:0]  ifid_write;
    logic [2:0]  ifid_flush;
    logic [2:0]  idex_bubble;
    logic [2:0]  exmem_flush;
    logic [1:0]  hz  [3];
    logic [15:0] sc  [3];
    logic [15:0] fc  [3];

    int lsc_p [3] = '{1, 3, 4};
    int br_p  [3] = '{1, 2, 0};

    int st_rem [3];
    int fl_rem [3];
    int m_sc   [3];
    int m_fc   [3];

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .BR_FLUSH_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .pc_write(pc_write[0]),
        .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]),
        .idex_bubble(idex_bubble[0]), .exmem_flush(exmem_flush[0]),
        .hz_state(hz[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0]));

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .BR_FLUSH_CYCLES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .pc_write(pc_write[1]),
        .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]),
        .idex_bubble(idex_bubble[1]), .exmem_flush(exmem_flush[1]),
        .hz_state(hz[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]));

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(4), .BR_FLUSH_CYCLES(0)) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .pc_write(pc_write[2]),
        .ifid_write(ifid_write[2]), .ifid_flush(ifid_flush[2]),
        .idex_bubble(idex_bubble[2]), .exmem_flush(exmem_flush[2]),
        .hz_state(hz[2]), .stall_cnt(sc[2]), .flush_cnt(fc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ctl_of(input int d);
        return {pc_write[d], ifid_write[d], ifid_flush[d],
                idex_bubble[d], exmem_flush[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            st_rem[d] = 0;
            fl_rem[d] = 0;
            m_sc[d]   = 0;
            m_fc[d]   = 0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_ctl%0d", tag, d), 32'(ctl_of(d)), 32'b11000);
            chk($sformatf("%s_hz%0d", tag, d), 32'(hz[d]), 32'd0);
            chk($sformatf("%s_sc%0d", tag, d), 32'(sc[d]), 32'd0);
            chk($sformatf("%s_fc%0d", tag, d), 32'(fc[d]), 32'd0);
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance model at the edge.
    task automatic step(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic urs, input logic urt, input logic mr,
                        input logic [2:0] ert, input logic br);
        logic       hzd;
        logic [4:0] exp_ctl [3];
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs;
        id_uses_rt = urt; ex_mem_read = mr; ex_rt = ert;
        mem_branch_taken = br;
        hzd = v && mr && ((urs && rs == ert) || (urt && rt == ert));
        #3;
        for (int d = 0; d < 3; d++) begin
            if (br)
                exp_ctl[d] = 5'b11111;
            else if (fl_rem[d] > 0)
                exp_ctl[d] = 5'b11100;
            else if (st_rem[d] > 0 || hzd)
                exp_ctl[d] = 5'b00010;
            else
                exp_ctl[d] = 5'b11000;
            chk($sformatf("ctl%0d", d), 32'(ctl_of(d)), 32'(exp_ctl[d]));
            chk($sformatf("hz%0d", d), 32'(hz[d]),
                (fl_rem[d] > 0) ? 32'd2 : (st_rem[d] > 0) ? 32'd1 : 32'd0);
            chk($sformatf("sc%0d", d), 32'(sc[d]), 32'(m_sc[d]));
            chk($sformatf("fc%0d", d), 32'(fc[d]), 32'(m_fc[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!exp_ctl[d][4] && m_sc[d] < 65535) m_sc[d]++;
            if (br && m_fc[d] < 65535) m_fc[d]++;
            if (br) begin
                fl_rem[d] = br_p[d];
                st_rem[d] = 0;
            end else if (fl_rem[d] > 0) begin
                fl_rem[d]--;
            end else if (st_rem[d] > 0) begin
                st_rem[d]--;
            end else if (hzd) begin
                st_rem[d] = lsc_p[d] - 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    // Reset pulse mid-cycle with a hazard still presented on the inputs.
    task automatic mid_reset();
        id_valid = 1'b1; id_rs = 3'd3; id_uses_rs = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 3'd3; mem_branch_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("rst_async");
        @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_rt = 0; mem_branch_taken = 0;
        model_reset();
        #2;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load-use on rs, then idle to drain the longest stall.
        step(1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        repeat (4) idle();
        // Register 0 still counts, via rt.
        step(1'b1, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        repeat (4) idle();
        // Hazard together with a taken branch.
        step(1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1);
        repeat (3) idle();
        // Back-to-back taken branches restart the flush.
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        repeat (3) idle();
        // Hazard ignored while flushing.
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0);
        repeat (5) idle();
        // Reset mid-stall.
        step(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0);
        idle();
        mid_reset();
        repeat (5) idle();

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0),
                     3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     3'($urandom_range(0, 3)),
                     1'($urandom_range(0, 9) == 0));
            end
        end

        // Saturation: continuous hazard for more than 0xFFFF stall cycles.
        mid_reset();
        for (int i = 0; i < 65537 + 8; i++) begin
            step(1'b1, 3'd6, 3'd6, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("sat%0d", d), 32'(sc[d]), 32'hFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
